uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter between N_SRC packet sources: the readback serializer, the status/heartbeat reporter and the TDC config echo.
- Grants are per packet and round-robin; a granted packet is never interleaved with another.
- Paces bytes to the transmitter with a start-pulse / ready handshake and a guard window.
- Aborts a packet if its source stalls for too long.

Parameters:
- N_SRC, 2, number of requesting sources (2..8).
- TX_GUARD, 2, cycles after tx_start during which tx_ready is ignored (min 1).
- IDLE_TIMEOUT, 1024, max consecutive stall cycles of the granted source before abort (min 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- src_valid  in  N_SRC  per-source byte valid; first valid byte while ungranted is the packet request.
- src_data  in  8*N_SRC  per-source byte, source i on bits [8i+7:8i].
- src_last  in  N_SRC  marks final byte of the packet, qualified by src_valid.
- src_ready  out  N_SRC  combinational byte accept; transfer = src_valid[i] & src_ready[i].
- tx_ready  in  1  UART idle (level).
- tx_start  out  1  one-cycle pulse, registered.
- tx_data  out  8  byte for UART, held stable from tx_start until the next tx_start.
- grant  out  N_SRC  one-hot current owner, registered; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- pkt_done  out  1  one-cycle pulse when a packet's last byte has left the UART.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: state IDLE, all outputs 0, RR pointer = 0, stall and guard counters 0.
- Reset mid-packet drops the packet. A byte already started in the UART still completes there and is not tracked.
- IDLE:
  - If any src_valid is set, pick the first set bit scanning from pointer, pointer+1, … modulo N_SRC.
  - Register grant one-hot and go to SEND.
  - src_ready stays 0 in IDLE.
- SEND:
  - src_ready[g] = grant[g] & tx_ready & (state==SEND); all other src_ready bits are 0.
  - On a transfer: capture byte and last flag, tx_start=1 and tx_data=byte on the next edge, clear stall counter, go to GUARD.
  - Without a transfer: stall counter increments when src_valid[g] is low.
  - On reaching IDLE_TIMEOUT: timeout_err pulse, grant←0, pointer←g+1, go to IDLE.
  - tx_ready low with src_valid high is not a stall.
- GUARD:
  - Count TX_GUARD cycles while ignoring tx_ready, then go to WAIT_TX.
  - This covers transmitters whose ready drops one cycle late.
- WAIT_TX:
  - Wait for tx_ready=1.
  - If the captured last flag was 0, return to SEND.
  - If it was 1, pkt_done pulse, grant←0, pointer←(g+1) mod N_SRC, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 → grant at cycle 1.
  - First src_ready at cycle 1 if tx_ready is high → tx_start at cycle 2.
- Byte period = max(UART frame, 1 + TX_GUARD + 1) cycles.
- Requests arriving while busy wait; there is no preemption.
- A source asserting src_valid while not granted is never acknowledged.
- Single-byte packet: src_last on the first byte; pkt_done follows that byte's WAIT_TX.
- Rotation:
  - After a packet, the owner drops to lowest priority, so a continuously requesting source cannot starve the others.
  - With N_SRC=1 the pointer stays 0.
- Counters:
  - Stall counter width = clog2(IDLE_TIMEOUT+1), saturating.
  - Guard counter width = clog2(TX_GUARD+1).

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (IDLE, SEND, GUARD, WAIT_TX);
  - byte width constant 8;
  - clog2 helper function.
- Sub-module rr_arbiter: combinational N-way round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and grant index.
  - Reused later for the command-FIFO dispatcher.

Test Plan:
- Single source: src0 sends 4-byte packet AA 01 02 03, tx_ready high except 10 cycles after each start.
  - Expect tx_data sequence AA,01,02,03; exactly 4 tx_start; one pkt_done; grant 01→00.
- Simultaneous requests: src0 and src1 both valid in IDLE after reset, each with 2-byte packets, both resubmitting continuously.
  - Expect grant order 01,10,01,10.
  - Expect no byte interleave.
- Late ready: tx_ready stays high 1 cycle after tx_start, then low 20 cycles.
  - Expect no second tx_start inside the guard window; next byte starts only after tx_ready returns.
- Timeout: src1 granted, sends 1 non-last byte, then src_valid low with IDLE_TIMEOUT=16.
  - Expect timeout_err pulse, grant→0, no pkt_done.
  - Expect a pending src0 granted next.
- Reset mid-packet: assert reset during WAIT_TX of byte 2 of 4.
  - Expect all outputs 0 the next cycle.
  - Expect no further tx_start.
  - After release, a new src0 packet starts cleanly from its first byte.
- Stall without timeout: granted src0 drops valid for 10 cycles (< IDLE_TIMEOUT) mid-packet.
  - Expect packet completes intact, no timeout_err.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD,
        WAIT_TX
    } arb_state_t;

    // Bits needed to hold values 0..value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: the first set request bit found
// scanning upward from the pointer (wrapping) wins.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan from the farthest offset back toward the pointer so the closest requester is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                         = '0;
                gnt[(int'(ptr) + k) % N]    = 1'b1;
                gnt_idx                     = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between N_SRC packet sources. Ownership is
// granted per packet in round-robin order, bytes are paced with a start pulse,
// a guard window and a ready wait, and a stalled owner is aborted after a timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_SRC        = 2,
    parameter int TX_GUARD     = 2,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [BYTE_W*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]          src_last,
    output logic [N_SRC-1:0]          src_ready,
    input  logic                      tx_ready,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    output logic [N_SRC-1:0]          grant,
    output logic                      busy,
    output logic                      pkt_done,
    output logic                      timeout_err
);

    localparam int IDX_W   = (N_SRC > 1) ? clog2(N_SRC) : 1;
    localparam int STALL_W = clog2(IDLE_TIMEOUT + 1);
    localparam int GUARD_W = (TX_GUARD > 1) ? clog2(TX_GUARD + 1) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_SRC - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(IDLE_TIMEOUT);
    localparam logic [GUARD_W-1:0] GUARD_END   = GUARD_W'(TX_GUARD - 1);

    arb_state_t           state_q, state_n;
    logic [N_SRC-1:0]     grant_q, grant_n;
    logic [IDX_W-1:0]     owner_q, owner_n;
    logic [IDX_W-1:0]     ptr_q, ptr_n;
    logic [STALL_W-1:0]   stall_q, stall_n;
    logic [GUARD_W-1:0]   guard_q, guard_n;
    logic                 last_q, last_n;
    logic [BYTE_W-1:0]    tx_data_q, tx_data_n;
    logic                 tx_start_q, tx_start_n;
    logic                 pkt_done_q, pkt_done_n;
    logic                 timeout_q, timeout_n;

    logic [N_SRC-1:0]     pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic [BYTE_W-1:0]    owner_data;
    logic                 owner_valid;
    logic                 owner_last;
    logic                 xfer;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (src_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    // Only the owner may hand over a byte, and only while the UART is idle in SEND.
    always_comb begin
        src_ready = '0;
        if (state_q == SEND && tx_ready) src_ready = grant_q;
    end

    // Select the owner's byte, valid and last flag through the one-hot grant.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) owner_data = owner_data | src_data[i*BYTE_W +: BYTE_W];
        end
        owner_valid = |(src_valid & grant_q);
        owner_last  = |(src_last & grant_q);
        xfer        = |(src_valid & src_ready);
        next_ptr    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end

    // Packet-level sequencing: arbitrate, hand bytes to the UART, guard, wait, release or abort.
    always_comb begin
        state_n    = state_q;
        grant_n    = grant_q;
        owner_n    = owner_q;
        ptr_n      = ptr_q;
        stall_n    = stall_q;
        guard_n    = guard_q;
        last_n     = last_q;
        tx_data_n  = tx_data_q;
        tx_start_n = 1'b0;
        pkt_done_n = 1'b0;
        timeout_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|src_valid) begin
                    grant_n = pick_gnt;
                    owner_n = pick_idx;
                    stall_n = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_data_n  = owner_data;
                    last_n     = owner_last;
                    tx_start_n = 1'b1;
                    stall_n    = '0;
                    guard_n    = '0;
                    state_n    = GUARD;
                end else if (!owner_valid) begin
                    if (stall_q + 1'b1 == STALL_LIMIT) begin
                        timeout_n = 1'b1;
                        grant_n   = '0;
                        ptr_n     = next_ptr;
                        stall_n   = '0;
                        state_n   = IDLE;
                    end else if (stall_q != '1) begin
                        stall_n = stall_q + 1'b1;
                    end
                end else begin
                    stall_n = '0;
                end
            end
            GUARD: begin
                if (guard_q == GUARD_END) begin
                    guard_n = '0;
                    state_n = WAIT_TX;
                end else begin
                    guard_n = guard_q + 1'b1;
                end
            end
            WAIT_TX: begin
                if (tx_ready) begin
                    if (last_q) begin
                        pkt_done_n = 1'b1;
                        grant_n    = '0;
                        ptr_n      = next_ptr;
                        state_n    = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; a synchronous reset drops any packet in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            stall_q    <= '0;
            guard_q    <= '0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            pkt_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            grant_q    <= grant_n;
            owner_q    <= owner_n;
            ptr_q      <= ptr_n;
            stall_q    <= stall_n;
            guard_q    <= guard_n;
            last_q     <= last_n;
            tx_data_q  <= tx_data_n;
            tx_start_q <= tx_start_n;
            pkt_done_q <= pkt_done_n;
            timeout_q  <= timeout_n;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign pkt_done    = pkt_done_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: source and UART models drive the DUT,
// a packet-level round-robin reference fills a scoreboard that a monitor drains.
module tb_uart_tx_arbiter;

    localparam int N_SRC        = 2;
    localparam int TX_GUARD     = 2;
    localparam int IDLE_TIMEOUT = 16;
    localparam int MIN_GAP      = TX_GUARD + 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } src_byte_t;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_SRC-1:0]     src_valid;
    logic [8*N_SRC-1:0]   src_data;
    logic [N_SRC-1:0]     src_last;
    logic [N_SRC-1:0]     src_ready;
    logic                 tx_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [N_SRC-1:0]     grant;
    logic                 busy;
    logic                 pkt_done;
    logic                 timeout_err;

    src_byte_t        src_q   [N_SRC][$];
    src_byte_t        model_q [N_SRC][$];
    src_byte_t        stage_q [$];
    exp_t             exp_q   [$];
    int               hold_cnt [N_SRC];
    logic [N_SRC-1:0] pending;

    int frame_len = 10;
    int late_len = 0;
    int uart_late_left = 0;
    int uart_low_left = 0;
    int model_ptr = 0;
    int checks = 0;
    int errors = 0;
    int starts_seen = 0;
    int done_seen = 0;
    int timeout_seen = 0;
    int exp_done = 0;
    int exp_timeouts = 0;
    int cycle = 0;
    int last_start_cycle = -1000;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_SRC        (N_SRC),
        .TX_GUARD     (TX_GUARD),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant       (grant),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stageByte(input logic [7:0] data, input logic last, input int gap);
        src_byte_t b;
        b.data = data;
        b.last = last;
        b.gap  = gap;
        stage_q.push_back(b);
    endtask

    // Hands the staged bytes to a source; the reference model only sees complete packets.
    task automatic applyStimulus(input int src, input bit to_model);
        foreach (stage_q[k]) begin
            src_q[src].push_back(stage_q[k]);
            if (to_model) model_q[src].push_back(stage_q[k]);
        end
        stage_q.delete();
    endtask

    function automatic bit modelPending();
        for (int s = 0; s < N_SRC; s++) begin
            if (model_q[s].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Packet-level reference: whole packets leave in round-robin order, owner drops to lowest priority.
    task automatic predict();
        int g;
        src_byte_t b;
        while (modelPending()) begin
            g = -1;
            for (int k = 0; k < N_SRC; k++) begin
                if (g < 0 && model_q[(model_ptr + k) % N_SRC].size() > 0) g = (model_ptr + k) % N_SRC;
            end
            while (model_q[g].size() > 0) begin
                b = model_q[g].pop_front();
                exp_q.push_back('{g, b.data});
                if (b.last) break;
            end
            exp_done++;
            model_ptr = (g + 1) % N_SRC;
        end
    endtask

    task automatic checkIdleOutputs();
        checkOutput("rst_tx_start", 32'(tx_start), 0);
        checkOutput("rst_tx_data", 32'(tx_data), 0);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_pkt_done", 32'(pkt_done), 0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 0);
        checkOutput("rst_src_ready", 32'(src_ready), 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
            src_q[s].delete();
            model_q[s].delete();
            hold_cnt[s] = 0;
        end
        exp_q.delete();
        pending = '0;
        model_ptr = 0;
        starts_seen = 0;
        @(negedge clk); #2;
        checkIdleOutputs();
        @(negedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_pkt_done_count"}, 32'(done_seen), 32'(exp_done));
        checkOutput({tag, "_timeout_count"}, 32'(timeout_seen), 32'(exp_timeouts));
        checkOutput({tag, "_grant_released"}, 32'(grant), 0);
        done_seen = 0;
        timeout_seen = 0;
        exp_done = 0;
        exp_timeouts = 0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0 || busy) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        checkOutput({tag, "_drained_in_budget"}, 32'(n < budget), 1);
    endtask

    task automatic waitGrant(input logic [N_SRC-1:0] want, input int budget);
        int n = 0;
        while (grant !== want && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        checkOutput("grant_reached", 32'(grant), 32'(want));
    endtask

    task automatic waitStarts(input int count, input int budget);
        int n = 0;
        while (starts_seen < count && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        checkOutput("starts_reached", 32'(starts_seen), 32'(count));
    endtask

    // Source and UART models: pop accepted bytes, shape tx_ready after each start, present next bytes.
    initial begin : driver
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        tx_ready  = 1'b1;
        pending   = '0;
        for (int s = 0; s < N_SRC; s++) hold_cnt[s] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_SRC; i++) begin
                if (pending[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    if (src_q[i].size() > 0) hold_cnt[i] = src_q[i][0].gap;
                end
            end
            if (tx_start) begin
                checkOutput("tx_start_while_uart_busy", 32'(uart_late_left > 0 || uart_low_left > 0), 0);
                uart_late_left = late_len;
                uart_low_left  = frame_len;
            end
            if (uart_late_left > 0) begin
                tx_ready = 1'b1;
                uart_late_left--;
            end else if (uart_low_left > 0) begin
                tx_ready = 1'b0;
                uart_low_left--;
            end else begin
                tx_ready = 1'b1;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (src_q[i].size() > 0 && hold_cnt[i] == 0) begin
                    src_valid[i]       = 1'b1;
                    src_data[i*8 +: 8] = src_q[i][0].data;
                    src_last[i]        = src_q[i][0].last;
                end else begin
                    src_valid[i]       = 1'b0;
                    src_data[i*8 +: 8] = 8'h00;
                    src_last[i]        = 1'b0;
                    if (hold_cnt[i] > 0 && src_q[i].size() > 0) hold_cnt[i]--;
                end
            end
            #1;
            checkOutput("src_ready_outside_grant", 32'(src_ready & ~grant), 0);
            pending = src_valid & src_ready & {N_SRC{~reset}};
        end
    end

    // Scoreboard monitor: every start must match the next expected byte and owner.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (tx_start) begin
                starts_seen++;
                checkOutput("start_spacing_ok", 32'(cycle - last_start_cycle >= MIN_GAP), 1);
                last_start_cycle = cycle;
                checkOutput("tx_start_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("tx_data", 32'(tx_data), 32'(e.data));
                    checkOutput("grant_owner", 32'(grant), 32'(1 << e.src));
                end
            end
            if (pkt_done) begin
                done_seen++;
                checkOutput("grant_zero_at_pkt_done", 32'(grant), 0);
            end
            if (timeout_err) begin
                timeout_seen++;
                checkOutput("grant_zero_at_timeout", 32'(grant), 0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized rounds checked against the reference model.
    initial begin : main
        doReset();

        frame_len = 10;
        late_len = 0;
        stageByte(8'hAA, 1'b0, 0);
        stageByte(8'h01, 1'b0, 0);
        stageByte(8'h02, 1'b0, 0);
        stageByte(8'h03, 1'b1, 0);
        applyStimulus(0, 1'b1);
        predict();
        waitDrain("single", 400);
        checkOutput("single_start_count", 32'(starts_seen), 4);
        checkCounts("single");

        doReset();
        frame_len = 3;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < N_SRC; s++) begin
                stageByte(8'($urandom_range(0, 255)), 1'b0, 0);
                stageByte(8'($urandom_range(0, 255)), 1'b1, 0);
                applyStimulus(s, 1'b1);
            end
        end
        predict();
        waitDrain("simultaneous", 400);
        checkCounts("simultaneous");

        doReset();
        frame_len = 20;
        late_len = 1;
        for (int j = 0; j < 3; j++) stageByte(8'($urandom_range(0, 255)), 1'(j == 2), 0);
        applyStimulus(0, 1'b1);
        predict();
        waitDrain("late_ready", 400);
        checkCounts("late_ready");
        late_len = 0;

        doReset();
        frame_len = 4;
        stageByte(8'h5A, 1'b0, 0);
        applyStimulus(1, 1'b0);
        exp_q.push_back('{1, 8'h5A});
        exp_timeouts = 1;
        waitGrant(2'b10, 50);
        stageByte(8'hC1, 1'b0, 0);
        stageByte(8'hC2, 1'b0, 0);
        stageByte(8'hC3, 1'b1, 0);
        applyStimulus(0, 1'b1);
        predict();
        waitDrain("timeout", 400);
        checkCounts("timeout");

        doReset();
        frame_len = 10;
        for (int j = 0; j < 4; j++) stageByte(8'(8'h10 + j), 1'(j == 3), 0);
        applyStimulus(0, 1'b1);
        predict();
        waitStarts(2, 200);
        @(negedge clk); #2;
        @(negedge clk); #2;
        checkOutput("bytes_left_at_reset", 32'(exp_q.size()), 2);
        exp_done = 0;
        done_seen = 0;
        doReset();
        repeat (15) @(negedge clk);
        #2;
        checkOutput("no_start_after_reset", 32'(starts_seen), 0);
        for (int j = 0; j < 4; j++) stageByte(8'(8'h20 + j), 1'(j == 3), 0);
        applyStimulus(0, 1'b1);
        predict();
        waitDrain("reset_mid", 400);
        checkCounts("reset_mid");

        doReset();
        frame_len = 3;
        stageByte(8'h31, 1'b0, 0);
        stageByte(8'h32, 1'b0, 0);
        stageByte(8'h33, 1'b0, 10);
        stageByte(8'h34, 1'b0, 0);
        stageByte(8'h35, 1'b1, 0);
        applyStimulus(0, 1'b1);
        predict();
        waitDrain("stall", 400);
        checkCounts("stall");

        doReset();
        for (int r = 0; r < 8; r++) begin
            frame_len = $urandom_range(1, 6);
            late_len  = $urandom_range(0, 1);
            for (int s = 0; s < N_SRC; s++) begin
                int npkt;
                npkt = $urandom_range(0, 3);
                for (int p = 0; p < npkt; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        stageByte(8'($urandom_range(0, 255)), 1'(j == len - 1), (j == 0) ? 0 : $urandom_range(0, 6));
                    end
                end
                applyStimulus(s, 1'b1);
            end
            predict();
            waitDrain("random", 2000);
            checkCounts("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
